// File: rtl/sram_b_reader.sv
// sram_b_reader: streams a wrapping burst of words from a 1-cycle-latency SRAM through a 3-entry FIFO.
// Optional out_last output is enabled by defining SRAM_B_READER_LAST_EN.
module sram_b_reader #(
  parameter int WORD_AMOUNT = 56,
  parameter int DATA_W = 129,
  parameter int AW = $clog2(WORD_AMOUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       len,
  output logic              busy,
  output logic              done,
  output logic              sram_we,
  output logic [AW-1:0]     sram_addr,
  input  logic [DATA_W-1:0] sram_dout,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef SRAM_B_READER_LAST_EN
  ,
  output logic              out_last
`endif
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] state;
  logic [AW:0] rd_left, out_left;
  logic addr_v, data_v, zero_done;
  logic [DATA_W-1:0] fifo [3];
  logic [1:0] wr_ptr, rd_ptr, count;
  logic accept, issue, pop, last_xfer;
  logic [2:0] pending;
  assign accept = state == IDLE && start && len != '0;
  assign pop = out_valid && out_ready;
  // A slot vacated by this cycle's transfer is already free, which keeps one word per cycle.
  assign pending = 3'(count) - 3'(pop) + 3'(addr_v) + 3'(data_v);
  assign issue = state == RUN && rd_left != '0 && pending < 3'd3;
  assign out_valid = count != 2'd0;
  assign out_data = fifo[rd_ptr];
  assign last_xfer = state == DRAIN && pop && out_left == (AW+1)'(1);
  assign done = last_xfer || zero_done;
  assign busy = state != IDLE;
  assign sram_we = 1'b0;
`ifdef SRAM_B_READER_LAST_EN
  assign out_last = out_valid && state == DRAIN && out_left == (AW+1)'(1);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_left <= '0;
      out_left <= '0;
      addr_v <= 1'b0;
      data_v <= 1'b0;
      zero_done <= 1'b0;
      sram_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < 3; i++) fifo[i] <= '0;
    end else begin
      zero_done <= state == IDLE && start && len == '0;
      addr_v <= accept || issue;
      data_v <= addr_v;
      if (accept) begin
        state <= RUN;
        sram_addr <= base_addr;
        rd_left <= len - (AW+1)'(1);
        out_left <= len;
      end
      if (issue) begin
        sram_addr <= sram_addr == AW'(WORD_AMOUNT-1) ? '0 : sram_addr + 1'b1;
        rd_left <= rd_left - (AW+1)'(1);
      end
      if (state == RUN && rd_left == '0) state <= DRAIN;
      if (last_xfer) state <= IDLE;
      if (pop) begin
        rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
        out_left <= out_left - (AW+1)'(1);
      end
      if (data_v) begin
        fifo[wr_ptr] <= sram_dout;
        wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
      end
      count <= count + {1'b0, data_v} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_sram_b_reader.sv
// tb_sram_b_reader: directed bench for sram_b_reader with a word[i]=i SRAM model.
module tb_sram_b_reader;
  localparam int WA = 56, DW = 129, AW = 6;
  logic clk = 0, rst = 1, start = 0, out_ready = 1;
  logic [AW-1:0] base_addr = '0, sram_addr;
  logic [AW:0] len = '0;
  logic busy, done, sram_we, out_valid;
  logic [DW-1:0] sram_dout = '0, out_data;
  int checks = 0, failures = 0;
`ifdef SRAM_B_READER_LAST_EN
  logic out_last;
`endif
  sram_b_reader #(.WORD_AMOUNT(WA), .DATA_W(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef SRAM_B_READER_LAST_EN
    , .out_last(out_last)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] word(input int i);
    logic [DW-1:0] w;
    w = DW'(i);
    return w | (w << 120);
  endfunction
  always @(posedge clk) sram_dout <= word(int'(sram_addr));
  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic burst(input int b, input int n, input bit tog, input bit restart);
    int got = 0;
    bit stall = 0;
    bit xfer;
    logic [DW-1:0] held = '0;
    @(negedge clk);
    start = 1; base_addr = AW'(b); len = (AW+1)'(n); out_ready = 1;
    @(negedge clk);
    for (int c = 0; c < 200 && got < n; c++) begin
      start = restart && c == 1;
      if (start) begin base_addr = 6'd20; len = 7'd3; end
      out_ready = tog ? (c % 2 == 0) : 1'b1;
      #1;
      if (!tog && c < n) chk("addr", {1'b0, DW'(sram_addr)}, {1'b0, DW'((b + c) % WA)});
      if (!tog && c < 2) chk("latency", {1'b0, DW'(out_valid)}, '0);
      if (stall) begin
        chk("hold_valid", {1'b0, DW'(out_valid)}, 1);
        chk("hold_data", {1'b0, out_data}, {1'b0, held});
      end
      xfer = out_valid && out_ready;
      chk("done", {1'b0, DW'(done)}, {1'b0, DW'(xfer && got == n - 1)});
      if (xfer) begin
        chk("data", {1'b0, out_data}, {1'b0, word((b + got) % WA)});
        if (!tog) chk("rate", {1'b0, DW'(c)}, {1'b0, DW'(got + 2)});
`ifdef SRAM_B_READER_LAST_EN
        chk("last", {1'b0, DW'(out_last)}, {1'b0, DW'(got == n - 1)});
`endif
        got++;
      end
      held = out_data;
      stall = out_valid && !out_ready;
      @(negedge clk);
    end
    start = 0;
    chk("count", {1'b0, DW'(got)}, {1'b0, DW'(n)});
    chk("end_busy", {1'b0, DW'(busy)}, '0);
    chk("end_done", {1'b0, DW'(done)}, '0);
    chk("end_valid", {1'b0, DW'(out_valid)}, '0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {1'b0, DW'(busy)}, '0);
    chk("rst_valid", {1'b0, DW'(out_valid)}, '0);
    chk("rst_addr", {1'b0, DW'(sram_addr)}, '0);
    chk("rst_we", {1'b0, DW'(sram_we)}, '0);
    chk("rst_data", {1'b0, out_data}, '0);
    rst = 0;
    burst(0, 4, 0, 0);
    burst(54, 4, 0, 0);
    burst(3, 8, 1, 0);
    @(negedge clk);
    start = 1; base_addr = 6'd7; len = '0;
    @(negedge clk);
    start = 0;
    chk("z_done", {1'b0, DW'(done)}, 1);
    chk("z_busy", {1'b0, DW'(busy)}, '0);
    chk("z_valid", {1'b0, DW'(out_valid)}, '0);
    @(negedge clk);
    chk("z_done2", {1'b0, DW'(done)}, '0);
    chk("z_valid2", {1'b0, DW'(out_valid)}, '0);
    start = 1; base_addr = 6'd0; len = 7'd6;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    chk("pre_rst_data", {1'b0, out_data}, {1'b0, word(2)});
    rst = 1;
    #1;
    chk("ar_busy", {1'b0, DW'(busy)}, '0);
    chk("ar_done", {1'b0, DW'(done)}, '0);
    chk("ar_valid", {1'b0, DW'(out_valid)}, '0);
    chk("ar_addr", {1'b0, DW'(sram_addr)}, '0);
    chk("ar_data", {1'b0, out_data}, '0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {1'b0, DW'({busy, done, out_valid})}, '0);
    end
    burst(10, 2, 0, 0);
    burst(50, 9, 0, 1);
    burst(5, 1, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
